tx_pulser: RTL

TX_PULSER -- requirements
Module: tx_pulser

---
 rtl/beamform_pkg.sv | 21 ++
 rtl/pulser_channel.sv | 150 +++++++++++++++
 rtl/tx_pulser.sv | 57 +++++
 3 files changed

// File: rtl/beamform_pkg.sv
// beamform_pkg: shared constants and types for the transmit pulser.
//   NUM_CH            default number of transducer channels
//   DEF_*             default carrier timing and burst limit (in clock cycles)
//   ch_state_e        per-channel pulser state
package beamform_pkg;

  localparam int NUM_CH          = 8;
  localparam int DEF_HIGH_CYCLES = 1550;
  localparam int DEF_DEAD_CYCLES = 12;
  localparam int DEF_MAX_PULSES  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POS,
    ST_DEAD_PN,
    ST_NEG,
    ST_DEAD_NP,
    ST_HOLD
  } ch_state_e;

endpackage

// File: rtl/pulser_channel.sv
// pulser_channel: one H-bridge channel. A gate rising edge (while enabled)
// starts a burst of bipolar carrier cycles: POS, dead, NEG, dead. Bursts end
// after the cycle in which the gate is low, or park in HOLD once MAX_PULSES
// cycles have been driven with the gate still high.
//   clock, reset   system clock, async active-high reset
//   i_enable       global enable; low forces IDLE on the next edge
//   i_gate         transmit window for this channel
//   o_pos_drive    high-side drive (registered)
//   o_neg_drive    low-side drive (registered)
//   o_busy         channel not in IDLE (registered)
//   o_hold         channel in HOLD after hitting the pulse limit (registered)
module pulser_channel
  import beamform_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int MAX_PULSES  = DEF_MAX_PULSES
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  input  logic i_gate,
  output logic o_pos_drive,
  output logic o_neg_drive,
  output logic o_busy,
  output logic o_hold
);

  localparam int TMR_MAX = (HIGH_CYCLES > DEAD_CYCLES) ? HIGH_CYCLES : DEAD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = $clog2(MAX_PULSES + 1);

  localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PULSES);

  ch_state_e        r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic             r_gate_q;

  logic             w_rise;
  logic [CNT_W-1:0] w_count_inc;

  assign w_rise      = i_gate & ~r_gate_q;
  assign w_count_inc = r_count + 1'b1;

  // Timer restarts at 0 on every state entry and is compared against the
  // dwell-minus-one, so it never wraps. Drives are set alongside the state
  // so they are glitch-free registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_count     <= '0;
      r_gate_q    <= 1'b0;
      o_pos_drive <= 1'b0;
      o_neg_drive <= 1'b0;
      o_busy      <= 1'b0;
      o_hold      <= 1'b0;
    end else begin
      r_gate_q <= i_gate;
      if (!i_enable) begin
        r_state     <= ST_IDLE;
        r_timer     <= '0;
        r_count     <= '0;
        o_pos_drive <= 1'b0;
        o_neg_drive <= 1'b0;
        o_busy      <= 1'b0;
        o_hold      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state     <= ST_POS;
              r_timer     <= '0;
              o_pos_drive <= 1'b1;
              o_busy      <= 1'b1;
            end
          end
          ST_POS: begin
            if (r_timer == HIGH_LAST) begin
              r_state     <= ST_DEAD_PN;
              r_timer     <= '0;
              o_pos_drive <= 1'b0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_DEAD_PN: begin
            if (r_timer == DEAD_LAST) begin
              r_state     <= ST_NEG;
              r_timer     <= '0;
              o_neg_drive <= 1'b1;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_NEG: begin
            if (r_timer == HIGH_LAST) begin
              r_state     <= ST_DEAD_NP;
              r_timer     <= '0;
              o_neg_drive <= 1'b0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_DEAD_NP: begin
            if (r_timer == DEAD_LAST) begin
              r_timer <= '0;
              if (i_gate && (w_count_inc < MAX_CNT)) begin
                r_state     <= ST_POS;
                r_count     <= w_count_inc;
                o_pos_drive <= 1'b1;
              end else if (i_gate) begin
                r_state <= ST_HOLD;
                r_count <= w_count_inc;
                o_hold  <= 1'b1;
              end else begin
                r_state <= ST_IDLE;
                r_count <= '0;
                o_busy  <= 1'b0;
              end
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_HOLD: begin
            if (!i_gate) begin
              r_state <= ST_IDLE;
              r_count <= '0;
              o_busy  <= 1'b0;
              o_hold  <= 1'b0;
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_count     <= '0;
            o_pos_drive <= 1'b0;
            o_neg_drive <= 1'b0;
            o_busy      <= 1'b0;
            o_hold      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/tx_pulser.sv
// tx_pulser: NUM_CH independent ultrasound transmit pulser channels.
//   clock, reset   125 MHz system clock, async active-high reset
//   enable         global transmit enable
//   gate           per-channel transmit window
//   pos_drive      per-channel high-side drive (registered)
//   neg_drive      per-channel low-side drive (registered)
//   busy           per-channel not-idle flag (registered)
//   fault          sticky: some channel hit the pulse limit; cleared by reset
module tx_pulser #(
  parameter int NUM_CH      = beamform_pkg::NUM_CH,
  parameter int HIGH_CYCLES = beamform_pkg::DEF_HIGH_CYCLES,
  parameter int DEAD_CYCLES = beamform_pkg::DEF_DEAD_CYCLES,
  parameter int MAX_PULSES  = beamform_pkg::DEF_MAX_PULSES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] gate,
  output logic [NUM_CH-1:0] pos_drive,
  output logic [NUM_CH-1:0] neg_drive,
  output logic [NUM_CH-1:0] busy,
  output logic              fault
);

  logic [NUM_CH-1:0] w_hold;
  logic              r_fault;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulser_channel #(
      .HIGH_CYCLES (HIGH_CYCLES),
      .DEAD_CYCLES (DEAD_CYCLES),
      .MAX_PULSES  (MAX_PULSES)
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .i_enable    (enable),
      .i_gate      (gate[g]),
      .o_pos_drive (pos_drive[g]),
      .o_neg_drive (neg_drive[g]),
      .o_busy      (busy[g]),
      .o_hold      (w_hold[g])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (|w_hold) begin
      r_fault <= 1'b1;
    end
  end

  // HOLD is itself registered, so OR-ing it in shows fault on the same cycle
  // the channel enters HOLD; the sticky register keeps it after HOLD ends.
  assign fault = r_fault | (|w_hold);

endmodule
